divider_seq: RTL

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/divider_seq.sv
// Sequential signed QM.N divider: restoring division on magnitudes, one quotient
// bit per clock, followed by a saturate-and-sign stage that enters DONE.
module divider_seq #(
  parameter int M = 16,
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [M+N-1:0]   i_num,
  input  logic [M+N-1:0]   i_den,
  input  logic             i_abs,
  output logic             o_busy,
  output logic             o_done,
  output logic [M+N-1:0]   o_data,
  output logic             o_sat,
  output logic             o_divzero
);

  localparam int W    = M + N;
  localparam int ITER = M + 2 * N;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER);
  localparam logic [W-1:0]  NSAT = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [ITER-1:0] r_quo;     // dividend shifts out at the top, quotient shifts in at the bottom
  logic [W:0]      r_rem;
  logic [W-1:0]    r_den;
  logic            r_sign;
  logic            r_abs;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_data;
  logic            r_sat;
  logic            r_divzero;

  // Unsigned magnitudes; the most negative value maps to 2^(W-1) without loss.
  logic [W-1:0] w_num_mag;
  logic [W-1:0] w_den_mag;
  assign w_num_mag = i_num[W-1] ? (~i_num + 1'b1) : i_num;
  assign w_den_mag = i_den[W-1] ? (~i_den + 1'b1) : i_den;

  // Trial subtraction: the borrow out of the extended difference decides the quotient bit.
  logic [W+1:0] w_shift;
  logic [W+1:0] w_diff;
  logic         w_ge;
  logic [W:0]   w_rem_next;
  assign w_shift    = {r_rem, r_quo[ITER-1]};
  assign w_diff     = w_shift - {2'b00, r_den};
  assign w_ge       = ~w_diff[W+1];
  assign w_rem_next = w_ge ? w_diff[W:0] : w_shift[W:0];

  logic         w_ovf;
  logic         w_divz;
  logic         w_sat;
  logic [W-1:0] w_mag;
  logic [W-1:0] w_result;
  assign w_ovf    = |r_quo[ITER-1:W-1];
  assign w_divz   = (r_den == '0);
  assign w_sat    = w_ovf | w_divz;
  assign w_mag    = w_sat ? NSAT : r_quo[W-1:0];
  assign w_result = (r_sign & ~r_abs) ? (~w_mag + 1'b1) : w_mag;

  // NOTE: every register, datapath included, is cleared by reset so a mid-CALC abort
  // leaves no stale operand or partial quotient behind; state uses <= throughout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_den     <= '0;
      r_sign    <= 1'b0;
      r_abs     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_data    <= '0;
      r_sat     <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_quo   <= {w_num_mag, {N{1'b0}}};
            r_rem   <= '0;
            r_den   <= w_den_mag;
            r_sign  <= i_num[W-1] ^ i_den[W-1];
            r_abs   <= i_abs;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (r_cnt == LAST) begin
            r_data    <= w_result;
            r_sat     <= w_sat;
            r_divzero <= w_divz;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[ITER-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_data    = r_data;
  assign o_sat     = r_sat;
  assign o_divzero = r_divzero;

endmodule
